// File: rtl/global_history_predictor_pkg.sv
// ============================================================================
// Package : bp_pkg
// Shared types and counter helpers for the global-history branch predictor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int HIST_W = 12;
    localparam int CTR_W  = 2;

    typedef logic [CTR_W-1:0] ctr_t;

    localparam ctr_t CTR_WEAK_NT = ctr_t'((1 << (CTR_W - 1)) - 1);
    localparam ctr_t CTR_MAX     = {CTR_W{1'b1}};
    localparam ctr_t CTR_MIN     = '0;

    typedef struct packed {
        logic [HIST_W-1:0] idx;
        logic              pred;
    } inflight_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_MAX) ? c : ctr_t'(c + ctr_t'(1));
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_MIN) ? c : ctr_t'(c - ctr_t'(1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/global_history_predictor_fifo.sv
// ============================================================================
// Module  : inflight_fifo
// In-order queue of unresolved predictions; push+pop while full is legal.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  inflight_t              wdata_i,
    output inflight_t              rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    inflight_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same edge, so a full queue can still accept.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: a slot is always written before it is read.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/global_history_predictor.sv
// ============================================================================
// Module  : global_history_predictor
// Path-history-indexed saturating-counter table with in-flight training queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module global_history_predictor
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [HIST_W-1:0]      PHistory,
    input  logic                   PredReq,
    output logic                   PredValid,
    output logic                   PredTaken,
    output logic                   Stall,
    input  logic                   Resolve,
    input  logic                   BranchTaken,
    output logic                   Mispredict,
    output logic                   Underflow,
    input  logic                   Flush,
    output logic [$clog2(DEPTH):0] InFlight
);

    localparam int TBL_N = 2 ** HIST_W;

    ctr_t      table_q [TBL_N];
    inflight_t w_head;
    inflight_t w_push_data;
    ctr_t      w_rd_ctr;
    ctr_t      w_train_ctr;
    logic      w_full;
    logic      w_empty;
    logic      w_accept;
    logic      w_train;

    logic      pred_valid_q, pred_valid_d;
    logic      pred_taken_q, pred_taken_d;
    logic      mispredict_q, mispredict_d;
    logic      underflow_q,  underflow_d;

    assign Stall    = w_full && !Resolve;
    assign w_accept = PredReq && !Flush && (!w_full || Resolve);
    assign w_train  = Resolve && !w_empty;

    // Combinational read of the current array gives read-before-write on a same-index train.
    assign w_rd_ctr    = table_q[PHistory];
    assign w_push_data = '{idx: PHistory, pred: w_rd_ctr[CTR_W-1]};
    assign w_train_ctr = BranchTaken ? sat_inc(table_q[w_head.idx])
                                     : sat_dec(table_q[w_head.idx]);

    inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_inflight_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (w_accept),
        .pop_i   (w_train),
        .flush_i (Flush),
        .wdata_i (w_push_data),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (InFlight)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < TBL_N; i++) begin
                table_q[i] <= CTR_WEAK_NT;
            end
        end else if (w_train) begin
            table_q[w_head.idx] <= w_train_ctr;
        end
    end

    always_comb begin
        pred_valid_d = w_accept;
        pred_taken_d = w_accept ? w_rd_ctr[CTR_W-1] : 1'b0;
        mispredict_d = w_train && (w_head.pred != BranchTaken);
        underflow_d  = Resolve && w_empty;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            mispredict_q <= mispredict_d;
            underflow_q  <= underflow_d;
        end
    end

    assign PredValid  = pred_valid_q;
    assign PredTaken  = pred_taken_q;
    assign Mispredict = mispredict_q;
    assign Underflow  = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_global_history_predictor.sv
// ============================================================================
// Module  : tb_global_history_predictor
// Directed, table-driven check of prediction, training, queue and flush paths.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_global_history_predictor;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] PHistory;
    logic        PredReq;
    logic        PredValid;
    logic        PredTaken;
    logic        Stall;
    logic        Resolve;
    logic        BranchTaken;
    logic        Mispredict;
    logic        Underflow;
    logic        Flush;
    logic [2:0]  InFlight;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    global_history_predictor #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .PHistory    (PHistory),
        .PredReq     (PredReq),
        .PredValid   (PredValid),
        .PredTaken   (PredTaken),
        .Stall       (Stall),
        .Resolve     (Resolve),
        .BranchTaken (BranchTaken),
        .Mispredict  (Mispredict),
        .Underflow   (Underflow),
        .Flush       (Flush),
        .InFlight    (InFlight)
    );

    typedef struct {
        logic        req;
        logic [11:0] idx;
        logic        res;
        logic        tk;
        logic        fl;
        logic        stall;
        logic        pv;
        logic        pt;
        logic        mp;
        logic        uf;
        logic [2:0]  inf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic req, logic [11:0] idx, logic res, logic tk, logic fl,
                                logic stall, logic pv, logic pt, logic mp, logic uf,
                                logic [2:0] inf);
        vec_t v;
        v.req = req; v.idx = idx; v.res = res; v.tk = tk; v.fl = fl;
        v.stall = stall; v.pv = pv; v.pt = pt; v.mp = mp; v.uf = uf; v.inf = inf;
        return v;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, id, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [11:0] idx, input logic res,
                         input logic tk, input logic fl);
        PredReq = req; PHistory = idx; Resolve = res; BranchTaken = tk; Flush = fl;
    endtask

    task automatic apply(input vec_t v, input int id);
        drive(v.req, v.idx, v.res, v.tk, v.fl);
        #1;
        chk("Stall", id, 32'(Stall), 32'(v.stall));
        @(posedge clock);
        #1;
        chk("PredValid", id, 32'(PredValid), 32'(v.pv));
        if (v.pv) chk("PredTaken", id, 32'(PredTaken), 32'(v.pt));
        chk("Mispredict", id, 32'(Mispredict), 32'(v.mp));
        chk("Underflow", id, 32'(Underflow), 32'(v.uf));
        chk("InFlight", id, 32'(InFlight), 32'(v.inf));
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 12'h3C3, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_InFlight", 0, 32'(InFlight), 32'd0);
        chk("rst_PredValid", 0, 32'(PredValid), 32'd0);
        chk("rst_Mispredict", 0, 32'(Mispredict), 32'd0);
        chk("rst_Underflow", 0, 32'(Underflow), 32'd0);
        chk("rst_Stall", 0, 32'(Stall), 32'd0);

        // Fill the queue with five distinct indices; the fifth rides on a resolve.
        vecs.push_back(mk(1, 12'h100, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h200, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1, 12'h300, 0, 0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 12'h400, 0, 0, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(1, 12'h500, 1, 0, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(1, 12'h600, 0, 0, 0, 1, 0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Train ABC up to saturation, then back down.
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 12'hABC, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Training follows the queued index, not the live history (003).
        vecs.push_back(mk(1, 12'h001, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h002, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 12'h003, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 12'h003, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 12'h001, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 12'h002, 0, 0, 0, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, 12'h003, 0, 0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Flush with resolve and request: head trained, request dropped, queue cleared.
        vecs.push_back(mk(1, 12'h010, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h020, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(1, 12'h030, 0, 0, 0, 0, 1, 0, 0, 0, 3));
        vecs.push_back(mk(1, 12'h040, 1, 1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 12'h010, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 12'h020, 0, 0, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, 12'h000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        // Same-index resolve and predict: read-before-write.
        vecs.push_back(mk(1, 12'h055, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12'h055, 1, 1, 0, 0, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 12'h055, 1, 1, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 12'h000, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i + 1);

        // Reset mid-operation discards in-flight work and restores the table.
        drive(1'b1, 12'h010, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk("mid_pt_before", 100, 32'(PredTaken), 32'd1);
        chk("mid_inf_before", 100, 32'(InFlight), 32'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("mid_inf_rst", 101, 32'(InFlight), 32'd0);
        chk("mid_pv_rst", 101, 32'(PredValid), 32'd0);
        drive(1'b1, 12'h010, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk("mid_pv_after", 102, 32'(PredValid), 32'd1);
        chk("mid_pt_after", 102, 32'(PredTaken), 32'd0);
        chk("mid_inf_after", 102, 32'(InFlight), 32'd1);
        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
